// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write bypass, hardwired zero
// register, and a valid/ready dump engine that streams every register out.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int BYPASS   = 0,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*XLEN-1:0] rdata,
  input  logic [NW-1:0]      we,
  input  logic [NW*AW-1:0]   waddr,
  input  logic [NW*XLEN-1:0] wdata,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AW-1:0]      dump_idx,
  output logic [XLEN-1:0]    dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_regs [DEPTH];
  logic [AW-1:0]     r_idx;
  logic [NR*XLEN-1:0] w_rdata;

  // Ports are visited in ascending order so the highest-index writer wins a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == '0))
          r_regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < NR; k++) begin
      w_rdata[k*XLEN +: XLEN] = r_regs[raddr[k*AW +: AW]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          if (we[j] && waddr[j*AW +: AW] == raddr[k*AW +: AW])
            w_rdata[k*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
        end
      end
      if (ZERO_REG != 0 && raddr[k*AW +: AW] == '0)
        w_rdata[k*XLEN +: XLEN] = '0;
    end
  end

  assign rdata = w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (dump_req) r_idx <= '0;
        SEND: if (dump_ready) r_idx <= (r_idx == AW'(DEPTH-1)) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (dump_req) w_next = SEND;
      SEND:    if (dump_ready && r_idx == AW'(DEPTH-1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Dump data reads the stored array directly, so same-cycle writes never leak in.
  assign dump_valid = (r_state == SEND);
  assign dump_busy  = (r_state == SEND) || (r_state == DONE);
  assign dump_done  = (r_state == DONE);
  assign dump_idx   = r_idx;
  assign dump_data  = (r_state == SEND && !(ZERO_REG != 0 && r_idx == '0)) ? r_regs[r_idx] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero-reg/no-bypass and no-zero/bypass)
// share stimulus; a table, random traffic and dump sequences are checked.
module tb_regfile_mp;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR*AW-1:0]   raddr;
  logic [NW-1:0]      we;
  logic [NW*AW-1:0]   waddr;
  logic [NW*XLEN-1:0] wdata;
  logic               dump_req;
  logic               dump_ready;

  logic [NR*XLEN-1:0] rdA, rdB;
  logic               dvA, dvB, dbA, dbB, dnA, dnB;
  logic [AW-1:0]      diA, diB;
  logic [XLEN-1:0]    ddA, ddB;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .BYPASS(0), .ZERO_REG(1)) dutA (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdA), .we(we), .waddr(waddr), .wdata(wdata),
    .dump_req(dump_req), .dump_valid(dvA), .dump_ready(dump_ready), .dump_idx(diA),
    .dump_data(ddA), .dump_busy(dbA), .dump_done(dnA));

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .BYPASS(1), .ZERO_REG(0)) dutB (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdB), .we(we), .waddr(waddr), .wdata(wdata),
    .dump_req(dump_req), .dump_valid(dvB), .dump_ready(dump_ready), .dump_idx(diB),
    .dump_data(ddB), .dump_busy(dbB), .dump_done(dnB));

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] mA [DEPTH];
  logic [XLEN-1:0] mB [DEPTH];

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] eA0, eA1, eB0, eB1;
  } vec_t;
  vec_t tbl [7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      mA[i] = '0;
      mB[i] = '0;
    end
  endtask

  // Architectural rule: a read sees the stored value, or the latest-port write when bypassing.
  function automatic logic [XLEN-1:0] readModel(input bit isB, input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (!isB && a == 0) return '0;
    v = isB ? mB[a] : mA[a];
    if (isB)
      for (int j = 0; j < NW; j++)
        if (we[j] && waddr[j*AW +: AW] == a) v = wdata[j*XLEN +: XLEN];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int j = 0; j < NW; j++) begin
      if (we[j]) begin
        if (waddr[j*AW +: AW] != 0) mA[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
        mB[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    we    = v.we;
    waddr = {v.wa1, v.wa0};
    wdata = {v.wd1, v.wd0};
    raddr = {v.ra1, v.ra0};
  endtask

  task automatic runDump(input bit toggle, input bit injectWrite);
    int beats;
    int cyc;
    bit rdy;
    we = '0;
    dump_req = 1'b1;
    #1;
    checkOutput("idle_valid_before_req", 32'(dvA), 32'd0);
    tick();
    dump_req = 1'b0;
    beats = 0;
    cyc = 0;
    rdy = 1'b1;
    while (beats < DEPTH && cyc < 200) begin
      dump_ready = rdy;
      we = '0;
      if (injectWrite && beats == 20 && !rdy) begin
        we = 2'b01;
        waddr[AW-1:0] = 5'd20;
        wdata[XLEN-1:0] = 32'h0BADF00D;
      end
      #1;
      checkOutput("dump_valid", 32'(dvA), 32'd1);
      checkOutput("dump_busy", 32'(dbA), 32'd1);
      checkOutput("dump_done_early", 32'(dnA), 32'd0);
      checkOutput("dump_idx", 32'(diA), 32'(beats));
      checkOutput("dump_data", ddA, (beats == 0) ? 32'd0 : mA[beats]);
      if (rdy) beats++;
      tick();
      if (toggle) rdy = !rdy;
      cyc++;
    end
    if (beats != DEPTH) checkOutput("dump_timeout", 32'(beats), 32'(DEPTH));
    dump_ready = 1'b0;
    we = '0;
    #1;
    checkOutput("done_pulse", 32'(dnA), 32'd1);
    checkOutput("done_valid", 32'(dvA), 32'd0);
    checkOutput("done_busy", 32'(dbA), 32'd1);
    checkOutput("done_idx_wrap", 32'(diA), 32'd0);
    tick();
    checkOutput("idle_done", 32'(dnA), 32'd0);
    checkOutput("idle_busy", 32'(dbA), 32'd0);
    checkOutput("idle_valid", 32'(dvA), 32'd0);
  endtask

  initial begin
    int beats;
    int cyc;
    tbl[0] = '{2'b11, 5'd0, 5'd0, 32'h12345678, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0, 32'h12345678, 32'h12345678};
    tbl[1] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h12345678, 32'h0};
    tbl[2] = '{2'b11, 5'd7, 5'd7, 32'hAAAA0000, 32'h5555FFFF, 5'd7, 5'd3, 32'h0, 32'h0, 32'h5555FFFF, 32'h0};
    tbl[3] = '{2'b01, 5'd3, 5'd0, 32'hCAFEF00D, 32'h0, 5'd3, 5'd7, 32'h0, 32'h5555FFFF, 32'hCAFEF00D, 32'h5555FFFF};
    tbl[4] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'h12345678};
    tbl[5] = '{2'b10, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 5'd5, 5'd3, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
    tbl[6] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h5555FFFF, 32'hDEADBEEF, 32'h5555FFFF};

    clearModel();
    raddr = '0; we = '0; waddr = '0; wdata = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    #12;
    checkOutput("reset_valid", 32'(dvA), 32'd0);
    checkOutput("reset_busy", 32'(dbA), 32'd0);
    checkOutput("reset_done", 32'(dnA), 32'd0);
    checkOutput("reset_idx", 32'(diA), 32'd0);
    checkOutput("reset_data", ddA, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i]);
      #1;
      checkOutput($sformatf("tbl%0d_A0", i), rdA[31:0], tbl[i].eA0);
      checkOutput($sformatf("tbl%0d_A1", i), rdA[63:32], tbl[i].eA1);
      checkOutput($sformatf("tbl%0d_B0", i), rdB[31:0], tbl[i].eB0);
      checkOutput($sformatf("tbl%0d_B1", i), rdB[63:32], tbl[i].eB1);
      tick();
    end

    // Asynchronous reset in the middle of a cycle clears the array at once.
    we = '0;
    raddr = {5'd7, 5'd5};
    #1;
    checkOutput("pre_reset_r5", rdA[31:0], 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_r5_A", rdA[31:0], 32'd0);
    checkOutput("reset_r5_B", rdB[31:0], 32'd0);
    checkOutput("reset_mid_valid", 32'(dvA), 32'd0);
    checkOutput("reset_mid_busy", 32'(dbA), 32'd0);
    clearModel();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int c = 0; c < 300; c++) begin
      we = 2'($urandom);
      for (int j = 0; j < NW; j++) begin
        waddr[j*AW +: AW] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        wdata[j*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(0, 3))
          0: raddr[k*AW +: AW] = waddr[AW-1:0];
          1: raddr[k*AW +: AW] = waddr[2*AW-1:AW];
          default: raddr[k*AW +: AW] = 5'($urandom);
        endcase
      end
      #1;
      for (int k = 0; k < NR; k++) begin
        checkOutput($sformatf("rand%0d_A%0d", c, k), rdA[k*XLEN +: XLEN], readModel(1'b0, raddr[k*AW +: AW]));
        checkOutput($sformatf("rand%0d_B%0d", c, k), rdB[k*XLEN +: XLEN], readModel(1'b1, raddr[k*AW +: AW]));
      end
      tick();
    end
    checkOutput("rand_dump_idle", 32'(dvA), 32'd0);

    for (int i = 0; i < DEPTH; i += 2) begin
      we = 2'b11;
      waddr = {5'(i + 1), 5'(i)};
      wdata = {32'((i + 1) * 32'h11), 32'(i * 32'h11)};
      tick();
    end
    runDump(1'b1, 1'b1);

    // Reset after beat 10: no done pulse, and a restart dumps an all-zero array.
    we = '0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    beats = 0;
    cyc = 0;
    while (beats < 11 && cyc < 50) begin
      if (dvA) beats++;
      tick();
      cyc++;
    end
    if (beats != 11) checkOutput("partial_dump_timeout", 32'(beats), 32'd11);
    checkOutput("partial_idx", 32'(diA), 32'd11);
    checkOutput("partial_valid", 32'(dvA), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(dvA), 32'd0);
    checkOutput("abort_busy", 32'(dbA), 32'd0);
    checkOutput("abort_done", 32'(dnA), 32'd0);
    checkOutput("abort_idx", 32'(diA), 32'd0);
    clearModel();
    @(negedge clk);
    rst = 1'b0;
    dump_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("abort_no_done", 32'(dnA), 32'd0);
    end
    runDump(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read integer register file.
- Generalised in data width, depth, read-port count and write-port count.
- Optional write-to-read bypass and optional hardwired zero register.
- A handshake-driven dump engine streams all registers to the debug/difftest side, replacing the simulation-only register print. It sits between decode (read ports) and writeback (write ports).

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, >=2.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- NR, 2, number of read ports, >=1.
- NW, 1, number of write ports, >=1.
- BYPASS, 0, 1 = a read returns same-cycle write data.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- raddr  in  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NR*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- we  in  NW  per-port write enable.
- waddr  in  NW*AW  write addresses.
- wdata  in  NW*XLEN  write data.
- dump_req  in  1  start dump; sampled in IDLE only.
- dump_valid  out  1  dump_idx/dump_data valid.
- dump_ready  in  1  consumer accepts the current beat.
- dump_idx  out  AW  index of the register being dumped.
- dump_data  out  XLEN  stored value of register dump_idx.
- dump_busy  out  1  high in SEND and DONE.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous assert, release synchronous to clk):
  - all DEPTH registers = 0;
  - FSM = IDLE, dump_idx = 0;
  - dump_valid = dump_busy = dump_done = 0, dump_data = 0;
  - rdata follows the (zero) array combinationally.
- Read path is combinational, zero latency: rdata[k] = reg[raddr[k]].
  - ZERO_REG=1 and raddr=0 -> 0, regardless of writes.
- Write: at posedge, each port j with we[j]=1 updates reg[waddr[j]] <= wdata[j].
  - ZERO_REG=1 and waddr[j]=0 -> write dropped.
  - Data is visible on rdata the cycle after the edge.
- Write conflict: if several ports write the same address in one cycle, the highest index j wins. Non-conflicting ports all commit.
- Bypass (BYPASS=1):
  - If any enabled write port targets raddr[k] (non-zero, or any address when ZERO_REG=0), rdata[k] = that port's wdata, highest j winning.
  - BYPASS=0: rdata shows the pre-edge value.
- Dump FSM states:
  - IDLE: dump_valid=0, dump_busy=0. dump_req=1 -> SEND with dump_idx=0.
  - SEND: dump_valid=1, dump_busy=1, dump_data = stored reg[dump_idx] (never bypassed; 0 for idx 0 when ZERO_REG=1).
    - Beat transfers when dump_valid & dump_ready at posedge.
    - On transfer with dump_idx<DEPTH-1: dump_idx increments.
    - On transfer with dump_idx=DEPTH-1: go to DONE, dump_idx wraps to 0.
    - dump_ready low: hold idx; dump_data tracks the live stored value, so writes to the held index are reflected.
  - DONE: dump_done=1, dump_valid=0, dump_busy=1 for exactly one cycle, then IDLE.
- dump_req is ignored outside IDLE; no re-arm until back in IDLE. A held-high dump_req restarts the dump on the cycle after DONE.
- Writes and reads are never stalled by the dump; the dump never modifies the register array.
- Reset mid-dump: immediately IDLE, idx=0, no dump_done pulse, array cleared.

Test Plan:
- Reset then read: assert rst mid-run after writing 0xDEADBEEF to r5 -> rdata for r5 = 0 immediately, dump_valid=0, dump_busy=0.
- Zero register (NW=2, ZERO_REG=1): write 0x12345678 to r0 on both ports -> rdata for r0 stays 0. With ZERO_REG=0, same write -> next cycle r0 = 0x12345678.
- Write conflict (NW=2): port0 writes 0xAAAA0000 and port1 writes 0x5555FFFF to r7 in one cycle -> next cycle r7 = 0x5555FFFF.
- Bypass: BYPASS=1, write 0xCAFEF00D to r3 while raddr0=3 -> rdata0 = 0xCAFEF00D in the same cycle. BYPASS=0 -> old value (0) in that cycle, new value next cycle.
- Dump with backpressure: preload reg[i]=i*0x11; pulse dump_req; dump_ready toggles 1,0,1,...
  - 32 beats with dump_idx 0..31 and dump_data i*0x11 (0 for idx 0);
  - idx holds while dump_ready=0;
  - single dump_done pulse one cycle after the beat-31 handshake; then IDLE.
- Reset mid-dump: assert rst after beat 10 -> dump_valid falls asynchronously, no dump_done. A new dump_req then restarts at idx 0 with all data 0.
